// File: rtl/mar_mem_responder_if.sv
// mar_mem_responder_if
// Request/response bundle between a MAR-style requester and the word
// memory responder.
//   req/we/addr/wdata : requester -> responder, sampled only while idle
//   rdata             : registered read data
//   ack               : one-cycle completion pulse
//   busy              : access in flight; new requests are ignored
//   err               : completed access was out of range (only with ack)
interface mar_mem_responder_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        busy;
  logic        err;

  modport master (output req, we, addr, wdata, input  rdata, ack, busy, err);
  modport slave  (input  req, we, addr, wdata, output rdata, ack, busy, err);
endinterface

// File: rtl/mar_mem_responder.sv
// mar_mem_responder
// Word memory (2**DEPTH_LOG2 x 16) answering single requests after
// WAIT_CYCLES wait states. Request fields are captured on acceptance, so
// the requester may change them freely while busy.
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset (memory contents are kept)
//   bus   : slave side of mar_mem_responder_if
module mar_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mar_mem_responder_if.slave    bus
);
  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_ack;
  logic        r_busy;
  logic        r_err;

  logic [15:0] r_mem [DEPTH];

  // Any address bit above the array index makes the access out of range.
  logic w_oor;
  assign w_oor = |(r_addr >> DEPTH_LOG2);

  logic w_commit_wr;
  assign w_commit_wr = rst_n && (r_state == S_ACCESS) && r_we && !w_oor;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // ack/err are single-cycle pulses raised only by ACCESS
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_busy  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_ACCESS;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) r_state <= S_ACCESS;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_ACCESS: begin
          r_ack   <= 1'b1;
          r_err   <= w_oor;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (w_oor)      r_rdata <= '0;
          else if (!r_we) r_rdata <= r_mem[r_addr[DEPTH_LOG2-1:0]];
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; the write is gated by rst_n so a reset on the
  // ACCESS edge drops the write.
  always_ff @(posedge clk) begin
    if (w_commit_wr) r_mem[r_addr[DEPTH_LOG2-1:0]] <= r_wdata;
  end

  assign bus.rdata = r_rdata;
  assign bus.ack   = r_ack;
  assign bus.busy  = r_busy;
  assign bus.err   = r_err;
endmodule

// File: doc/mar_mem_responder.md
MAR_MEM_RESPONDER -- requirements
Module: mar_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning word-array address width (2**DEPTH_LOG2 words of 16 bits).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before each access (legal range 0..15).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port req  input  1  meaning access request, sampled only in IDLE.
REQ-006 SHALL have port we  input  1  meaning 1 = write, 0 = read, sampled with req.
REQ-007 SHALL have port addr  input  16  meaning word address driven by the MAR, sampled with req.
REQ-008 SHALL have port wdata  input  16  meaning write data, sampled with req.
REQ-009 SHALL have port rdata  output  16  meaning registered read data.
REQ-010 SHALL have port ack  output  1  meaning one-cycle completion pulse.
REQ-011 SHALL have port busy  output  1  meaning a request is in progress; new req is ignored.
REQ-012 SHALL have port err  output  1  meaning the completed access was out of range; valid while ack=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, ACCESS, with all outputs registered.
REQ-014 IDLE with req=1 SHALL latch addr, we and wdata, set busy=1, and go to WAIT with counter=WAIT_CYCLES; if WAIT_CYCLES=0 it SHALL go directly to ACCESS.
REQ-015 IDLE with req=0 SHALL hold state, keep busy=0, and hold rdata.
REQ-016 WAIT SHALL go to ACCESS at an edge where counter==1; otherwise it SHALL decrement the counter and stay in WAIT.
REQ-017 ACCESS SHALL perform the operation, set ack=1 for exactly one cycle, clear busy, and return to IDLE on the same edge.
REQ-018 Latency SHALL be: req accepted at edge E0, then ack high in the cycle after edge E0+WAIT_CYCLES+1.
REQ-019 Address range rule: addr[15:DEPTH_LOG2] nonzero SHALL be out of range; such an access SHALL set err=1 with ack, write nothing, and load rdata=16'h0000.
REQ-020 An in-range read SHALL load rdata with mem[addr[DEPTH_LOG2-1:0]] at the ACCESS edge, with err=0.
REQ-021 An in-range write SHALL store the latched wdata at the ACCESS edge, leave rdata unchanged, and set err=0.
REQ-022 Changes on req, we, addr or wdata while busy=1 SHALL have no effect; the latched copies govern the access.
REQ-023 Back-to-back operation: req=1 during the ack cycle (state IDLE) SHALL be accepted, so one access completes every WAIT_CYCLES+2 cycles.
REQ-024 rdata SHALL hold its last loaded value until the next read or out-of-range access completes.
REQ-025 err SHALL be 0 whenever ack=0.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force state=IDLE, counter=0, rdata=16'h0000, ack=0, busy=0, err=0.
REQ-027 Reset SHALL have priority over all transitions; a write whose ACCESS edge coincides with rst_n=0 SHALL NOT be committed.
REQ-028 Memory array contents SHALL NOT be cleared by reset.
REQ-029 After rst_n returns to 1, the first edge SHALL be able to accept req.

Verification
REQ-030 Write 16'hBEEF to addr 16'h0005, then read addr 16'h0005 -> write ack after 3 cycles with err=0; read ack with rdata=16'hBEEF (default parameters).
REQ-031 Read addr 16'h0100 with DEPTH_LOG2=8 -> ack=1, err=1, rdata=16'h0000; a prior write to addr 16'h0000 is unaffected.
REQ-032 Change addr from 16'h0003 to 16'h0007 while busy=1 -> the access uses 16'h0003.
REQ-033 Back-to-back reads of addr 1 and addr 2, with req held high through the ack cycle -> ack pulses 4 cycles apart with the correct data.
REQ-034 Assert rst_n=0 while in WAIT during a write of 16'h1234 to addr 9 -> outputs reset per REQ-026; a later read of addr 9 returns the old value.
REQ-035 With WAIT_CYCLES=0: accept req at edge E0 -> ack high in the cycle after E0+1.
